// File: rtl/inst_seq.sv
// Attention-pass instruction sequencer: walks Q/K write, K load, execute, drain, ofifo read, handshake and divide phases.
// Latency: every output is registered, so outputs trail the state/counter they decode by one cycle; done arrives 80 cycles after start at defaults.
// Backpressure: none beyond hsk_comp, which stalls in HSK up to hsk_tmo cycles; INST_SEQ_CLKGATE_EN selects decoded clock enables instead of constant 1.
module inst_seq #(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int drain       = 8,
    parameter int hsk_tmo     = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        hsk_comp,
    output logic [16:0] inst,
    output logic        div,
    output logic        qmem_clk_en,
    output logic        kmem_clk_en,
    output logic        mac_array_clk_en,
    output logic        sfp_row_clk_en,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int MAXA = (2 * total_cycle > hsk_tmo) ? 2 * total_cycle : hsk_tmo;
    localparam int MAXB = (MAXA > 10) ? MAXA : 10;
    localparam int MAXC = (MAXB > col + 1) ? MAXB : col + 1;
    localparam int MAXD = (MAXC > drain) ? MAXC : drain;
    localparam int MAXE = (MAXD > total_cycle + 2) ? MAXD : total_cycle + 2;
    // At least 5 bits so qkmem_add and pmem_add can always be sliced from the counter.
    localparam int CW   = ($clog2(MAXE + 1) > 5) ? $clog2(MAXE + 1) : 5;

    typedef enum logic [3:0] {
        IDLE, QWR, KWR, LOAD, LEND, GAP, EXEC, DRAIN, OFIFO, HSK, DIV, DONE
    } state_t;

    typedef struct packed {
        logic       ofifo_rd;
        logic [3:0] qkmem_add;
        logic [3:0] pmem_add;
        logic       execute;
        logic       load;
        logic       qmem_rd;
        logic       qmem_wr;
        logic       kmem_rd;
        logic       kmem_wr;
        logic       pmem_rd;
        logic       pmem_wr;
    } inst_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic          err_r;
    logic          tmo;
    inst_t         inst_d;
    logic          div_d;
    logic [3:0]    ce_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= (state_d != state || state == IDLE) ? '0 : cnt + CW'(1);
            if (state == IDLE && start)
                err_r <= 1'b0;
            else if (tmo)
                err_r <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        tmo     = 1'b0;
        unique case (state)
            IDLE:  if (start) state_d = QWR;
            QWR:   if (cnt == CW'(total_cycle - 1)) state_d = KWR;
            KWR:   if (cnt == CW'(col - 1)) state_d = LOAD;
            LOAD:  if (cnt == CW'(col)) state_d = LEND;
            LEND:  state_d = GAP;
            GAP:   if (cnt == CW'(9)) state_d = EXEC;
            EXEC:  if (cnt == CW'(total_cycle + 1)) state_d = DRAIN;
            DRAIN: if (cnt == CW'(drain - 1)) state_d = OFIFO;
            OFIFO: if (cnt == CW'(total_cycle - 1)) state_d = HSK;
            HSK: begin
                if (hsk_comp) begin
                    state_d = DIV;
                end else if (cnt == CW'(hsk_tmo - 1)) begin
                    state_d = DONE;
                    tmo     = 1'b1;
                end
            end
            DIV:   if (cnt == CW'(2 * total_cycle - 1)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_d = '0;
        div_d  = 1'b0;
        unique case (state)
            QWR: begin
                inst_d.qmem_wr   = 1'b1;
                inst_d.qkmem_add = cnt[3:0];
            end
            KWR: begin
                inst_d.kmem_wr   = 1'b1;
                inst_d.qkmem_add = cnt[3:0];
            end
            // The first LOAD cycle only primes the array; K reads start one cycle later.
            LOAD: begin
                inst_d.load      = 1'b1;
                inst_d.kmem_rd   = (cnt != '0);
                inst_d.qkmem_add = (cnt == '0) ? 4'd0 : cnt[3:0] - 4'd1;
            end
            LEND: inst_d.load = 1'b1;
            EXEC: begin
                inst_d.execute   = 1'b1;
                inst_d.qmem_rd   = 1'b1;
                inst_d.qkmem_add = cnt[3:0];
            end
            OFIFO: inst_d.ofifo_rd = 1'b1;
            DIV: begin
                inst_d.pmem_wr  = 1'b1;
                inst_d.pmem_add = cnt[4:1];
                div_d           = ~cnt[0];
            end
            default: ;
        endcase
    end

`ifdef INST_SEQ_CLKGATE_EN
    always_comb begin
        ce_d[3] = (state == QWR) || (state == EXEC);
        ce_d[2] = state inside {KWR, LOAD, LEND};
        ce_d[1] = state inside {LOAD, LEND, GAP, EXEC, DRAIN};
        ce_d[0] = state inside {OFIFO, HSK, DIV};
    end
`else
    assign ce_d = 4'b1111;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inst             <= '0;
            div              <= 1'b0;
            qmem_clk_en      <= 1'b0;
            kmem_clk_en      <= 1'b0;
            mac_array_clk_en <= 1'b0;
            sfp_row_clk_en   <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            inst             <= inst_d;
            div              <= div_d;
            qmem_clk_en      <= ce_d[3];
            kmem_clk_en      <= ce_d[2];
            mac_array_clk_en <= ce_d[1];
            sfp_row_clk_en   <= ce_d[0];
            busy             <= (state != IDLE);
            done             <= (state == DONE);
            err              <= err_r;
        end
    end

endmodule
